// File: rtl/result_uart_sender.sv
// Result word FIFO and hex-ASCII serialiser feeding a byte UART.
// Define RESULT_SENDER_CRLF_EN for a CR LF terminator instead of a space.
module result_uart_sender #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              transmit,
  output logic [7:0]        tx_byte,
  input  logic              is_transmitting,
  output logic              busy,
  output logic              overflow
);

  localparam int N    = DATA_W / 4;
  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = AW + 1;
`ifdef RESULT_SENDER_CRLF_EN
  localparam int TL = 2;
`else
  localparam int TL = 1;
`endif
  localparam logic [3:0] TERM_LEN = 4'(TL);
  localparam logic [3:0] LAST     = 4'(N + TL - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_IDLE,
    NEXT
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        left_q, left_d;
  logic              transmit_q, transmit_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;
  logic              push, pop;
  logic [7:0]        cur_char;

  assign in_ready = (count_q != CNTW'(FIFO_DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign transmit = transmit_q;
  assign tx_byte  = tx_byte_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character for the current position: digits first, terminator last.
  always_comb begin
    if (left_q >= TERM_LEN) begin
      cur_char = hex_ascii(shift_q[DATA_W-1 -: 4]);
    end
`ifdef RESULT_SENDER_CRLF_EN
    else if (left_q == 4'd1) begin
      cur_char = 8'h0D;
    end else begin
      cur_char = 8'h0A;
    end
`else
    else begin
      cur_char = 8'h20;
    end
`endif
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + CNTW'(1);
    if (!push && pop) count_d = count_q - CNTW'(1);
    overflow_d = overflow_q | (in_valid & ~in_ready);
  end

  // Frame sequencer, paced by the UART busy flag.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    left_d     = left_q;
    transmit_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          left_d  = LAST;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!is_transmitting) begin
          tx_byte_d  = cur_char;
          transmit_d = 1'b1;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (is_transmitting) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!is_transmitting) state_d = NEXT;
      end
      NEXT: begin
        if (left_q != 4'd0) begin
          left_d  = left_q - 4'd1;
          shift_d = shift_q << 4;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // All control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      shift_q    <= '0;
      left_q     <= '0;
      transmit_q <= 1'b0;
      tx_byte_q  <= 8'h00;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      left_q     <= left_d;
      transmit_q <= transmit_d;
      tx_byte_q  <= tx_byte_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/result_uart_sender.md
# result_uart_sender

Downstream formatting stage between a computation block's result output and the UART transmitter. Buffers result words in a small FIFO and serialises each one to the UART as uppercase ASCII hex digits (MSB nibble first) followed by a line terminator. Drives the UART `transmit`/`tx_byte` pair and paces itself on `is_transmitting`, so the top level never hand-drives the transmit strobe.

## Interface
- `DATA_W`, 8: result width in bits; a multiple of 4, 4..32; digits per word N = DATA_W/4.
- `FIFO_DEPTH`, 4: result words buffered; a power of two, ≥2.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `in_data` holds a result to send.
- `in_data`  in  DATA_W: result word.
- `in_ready`  out  1: FIFO not full; word accepted on an edge where `in_valid & in_ready`.
- `transmit`  out  1: one-cycle strobe to the UART's `transmit`.
- `tx_byte`  out  8: byte to the UART's `tx_byte`; valid while `transmit`=1.
- `is_transmitting`  in  1: from the UART; high while a byte is on the line.
- `busy`  out  1: a frame is in progress (state ≠ IDLE).
- `overflow`  out  1: sticky; set when `in_valid`=1 while `in_ready`=0 (word dropped); cleared only by `rst`.

## Operation
- FIFO: circular, with read/write pointers and a count of width log2(FIFO_DEPTH)+1. `in_ready` = (count ≠ FIFO_DEPTH), combinational. A push and a pop on the same edge leave count unchanged. A push while full is discarded and sets `overflow`.
- Encoding: nibble 0–9 → 0x30–0x39; nibble A–F → 0x41–0x46. Terminator: see Configuration.
- FSM:
  - IDLE: if count>0, pop the head word into the shift register, set digit index = N−1, go to SEND.
  - SEND: when `is_transmitting`=0, register `tx_byte` = current character, pulse `transmit` for one cycle, go to WAIT_BUSY.
  - WAIT_BUSY: wait for `is_transmitting`=1, then go to WAIT_IDLE.
  - WAIT_IDLE: wait for `is_transmitting`=0, then go to NEXT.
  - NEXT: if more characters remain (digits, then terminator bytes), advance and go to SEND; otherwise go to IDLE.
- Character order per word: digit N−1 … digit 0, then terminator byte(s).
- `tx_byte` holds its last value between strobes.
- Reset values (immediate, asynchronous): `transmit`=0, `tx_byte`=8'h00, `busy`=0, `overflow`=0, state IDLE, FIFO empty, so `in_ready`=1. A reset mid-frame abandons the frame; a byte already handed to the UART may still complete on the line.

## Timing
- Word accepted at edge k into an empty FIFO while IDLE: popped at edge k+1, and `transmit`=1 in the cycle following edge k+2 (2-edge latency), provided `is_transmitting`=0.
- `transmit` is high for exactly one cycle per character and is never reasserted until `is_transmitting` has gone high and then low again.
- Per-character overhead beyond the UART byte time: 3 cycles (WAIT_IDLE→NEXT→SEND→strobe).
- Back-to-back words: IDLE pops the next word on the edge after the last NEXT, with no extra idle cycles.
- `in_ready` may drop in the same cycle the FIFO fills; the upstream block must hold `in_valid`/`in_data` until a handshake occurs.

## Configuration
- `RESULT_SENDER_CRLF_EN` defined: terminator is two bytes, 0x0D then 0x0A; a frame is N+2 characters.
- Not defined: terminator is a single space, 0x20; a frame is N+1 characters.

## Test plan
- DATA_W=8, CRLF_EN, push 0x3C; UART model asserts `is_transmitting` for 10 cycles per byte → `tx_byte` sequence 0x33, 0x43, 0x0D, 0x0A, exactly four `transmit` pulses, `busy` falls after the 4th byte completes.
- CRLF_EN undefined, DATA_W=16, push 0xA0F9 → 0x41, 0x30, 0x46, 0x39, 0x20.
- FIFO_DEPTH=4, stall the UART with `is_transmitting`=1, push 6 words → first popped and held, `in_ready`=0 after 5 accepted, 6th dropped, `overflow`=1; release → 5 frames in push order.
- Push on the same edge that IDLE pops (count=1) → count stays 1; both words are sent, in order.
- Assert `rst` during the 2nd digit → `transmit`=0 and `tx_byte`=0x00 immediately, `busy`=0, `in_ready`=1; a fresh push 0x05 yields 0x30, 0x35, terminator.
- Hold `is_transmitting`=1 when entering SEND → no `transmit` strobe until it drops; the strobe then follows on the next edge.
